eject_rx_buffer: RTL and testbench
==================================

# eject_rx_buffer

Ejection-side receiver for the bufferless connect router. It captures flits presented on the router's `eject`/`push` outputs into a small first-word-fall-through FIFO. It drives `bfull` back to the router and hands flits to the local core over a valid/ready handshake. It sits between the router's ejection port and the node's network interface, one instance per router.

## Interface
Parameters:
- `FLIT_W`, 144, flit width; equals `` `control_w `` width from defines.v
- `DEPTH`, 4, FIFO entries; power of two, minimum 2
- `AW`, log2(DEPTH), pointer width (derived, not overridden)

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `eject` in FLIT_W: flit from router ejection port
- `push` in 1: router asserts to write `eject` this cycle
- `bfull` out 1: to router; high means the router must not push
- `dout` out FLIT_W: head flit to core
- `dout_valid` out 1: head entry valid
- `dout_ready` in 1: core accepts head this cycle
- `level` out AW+1: current occupancy, 0..DEPTH
- `overflow` out 1: sticky; set when a push arrives while full

## Operation
- Storage is a DEPTH-entry register array with write pointer `wp`, read pointer `rp` (AW bits, wrap modulo DEPTH) and occupancy counter `cnt` (AW+1 bits).
- Write: `push && !bfull` writes `eject` to `mem[wp]`, then `wp <= wp+1`.
- Read: `dout_valid && dout_ready` pops; `rp <= rp+1`.
- `cnt` update:
  - +1 on write only
  - −1 on pop only
  - unchanged on both or neither
- `bfull = (cnt == DEPTH)`. It is decoded from registered `cnt` only and never depends on `dout_ready`, so there is no combinational path core→router.
- Full with simultaneous pop: the push is still rejected, because `bfull` is high that cycle.
- Push while `bfull`: data is discarded, no state changes except `overflow <= 1`. `overflow` clears only on `rst`.
- `dout = mem[rp]`, `dout_valid = (cnt != 0)`. When `dout_valid` is low, `dout` is don't-care, but the bench requires it to be 0 after reset.
- `push` low: `eject` is ignored regardless of content.
- Flit contents (MSHR, seq, source, dest fields) are not interpreted; the flit passes bit-exact.
- Reset, including mid-operation:
  - `wp`, `rp`, `cnt` = 0; `overflow` = 0; all `mem` entries = 0
  - Outputs after reset: `bfull` 0, `dout_valid` 0, `dout` 0, `level` 0, `overflow` 0
  - Any in-flight push or pop in the reset cycle is ignored.

## Timing
- Write latency: a flit pushed at edge N appears on `dout` with `dout_valid` high in the cycle after edge N (1 cycle). There is no same-cycle bypass of `eject` to `dout`.
- A pop at edge N exposes the next entry in the cycle after edge N.
- `bfull` rises in the cycle after the edge that makes `cnt` = DEPTH. It falls in the cycle after the first pop from full.
- Sustained throughput is 1 flit/cycle when the core holds `dout_ready` high and the FIFO is non-full.
- `level` equals `cnt` (registered).

## Configuration
- `EJECT_RX_STATS_EN`:
  - Defined: adds output `rx_count` (32 bits). It increments on every accepted write and wraps at 2^32, and resets to 0.
  - Defined: adds output `drop_count` (16 bits). It increments on every rejected push, saturates at 0xFFFF, and resets to 0.
  - Undefined: neither port nor its counters exist; all other behaviour is identical.

## Test plan
- Reset and idle: hold `rst` 1 for 2 cycles with `push`=1 and `eject`=144'h011111111111111111111111111111111854 → after release, `dout_valid`=0, `level`=0, `bfull`=0, `overflow`=0, `dout`=0.
- Single flit: `push` 1 cycle with `eject`=144'h011111111111111111111111111111111854, `dout_ready`=0 → next cycle `dout_valid`=1, `dout` equals the pushed value, `level`=1. Then `dout_ready`=1 for 1 cycle → `dout_valid`=0, `level`=0.
- Fill and overflow: DEPTH=4, push 0xA0..0xA4 on consecutive cycles with `dout_ready`=0 → `bfull` is 1 from the cycle after the 4th push. 0xA4 is dropped and `overflow`=1. Draining yields 0xA0,0xA1,0xA2,0xA3 in order.
- Full plus simultaneous pop and push: at `cnt`=4, `push`=1 with 0xB0 and `dout_ready`=1 → 0xB0 is rejected, `level`=3, `overflow`=1. A push of 0xB1 the next cycle is accepted.
- Wrap-around streaming: push 10 flits 0x100..0x109 back-to-back with `dout_ready`=1 → the outputs match in order with 1-cycle latency, `level` never exceeds 1, and `bfull` stays 0.
- Reset mid-stream: with `level`=3, assert `rst` for 1 cycle → `level`=0 and `dout_valid`=0. With `EJECT_RX_STATS_EN`, `rx_count`=0 and `drop_count`=0.

Source files
------------

// File: rtl/eject_rx_buffer.sv
// eject_rx_buffer: first-word-fall-through receive FIFO on the router eject port.
// Define EJECT_RX_STATS_EN to add the rx_count / drop_count statistics outputs.
module eject_rx_buffer #(
  parameter  int FLIT_W = 144,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] eject,
  input  logic              push,
  output logic              bfull,
  output logic [FLIT_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [AW:0]       level,
  output logic              overflow
`ifdef EJECT_RX_STATS_EN
  ,
  output logic [31:0]       rx_count,
  output logic [15:0]       drop_count
`endif
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [AW:0]       cnt;
  logic              wr;
  logic              rd;
  logic              drop;

  // bfull comes from registered cnt only: no core-to-router comb path
  assign bfull      = (cnt == FULL_CNT);
  assign dout_valid = (cnt != '0);
  assign dout       = mem[rp];
  assign level      = cnt;

  assign wr   = push && !bfull;
  assign rd   = dout_valid && dout_ready;
  assign drop = push && bfull;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr) begin
      mem[wp] <= eject;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        wp <= wp + 1'b1;
      end
      if (rd) begin
        rp <= rp + 1'b1;
      end
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef EJECT_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (wr) begin
        rx_count <= rx_count + 1'b1;
      end
      if (drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eject_rx_buffer.sv
// tb_eject_rx_buffer: table vectors plus a flit scoreboard for eject_rx_buffer.
// Stats outputs are checked when EJECT_RX_STATS_EN is defined.
module tb_eject_rx_buffer;

  localparam int W     = 144;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam logic [W-1:0] T0 =
    144'h011111111111111111111111111111111854;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] eject;
  logic         push;
  logic         bfull;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic [AW:0]  level;
  logic         overflow;
`ifdef EJECT_RX_STATS_EN
  logic [31:0]  rx_count;
  logic [15:0]  drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int           mcnt = 0;
  logic         movf = 1'b0;
  logic [W-1:0] sb [$];
  int           mrx  = 0;
  int           mdrop = 0;

  always #5 clk = ~clk;

  eject_rx_buffer #(.FLIT_W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .eject      (eject),
    .push       (push),
    .bfull      (bfull),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .overflow   (overflow)
`ifdef EJECT_RX_STATS_EN
    ,
    .rx_count   (rx_count),
    .drop_count (drop_count)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: model the cycle, pop/compare the head, then check state.
  task automatic step();
    logic acc_w;
    logic acc_r;
    logic [W-1:0] e;
    acc_w = !rst && push && (mcnt != DEPTH);
    acc_r = !rst && dout_ready && (mcnt != 0);
    if (!rst) begin
      chk("dout_valid", W'(dout_valid), W'(mcnt != 0));
    end
    if (acc_r) begin
      if (sb.size() == 0) begin
        chk("sb_empty", W'(1), W'(0));
      end else begin
        e = sb.pop_front();
        chk("dout", dout, e);
      end
    end
    if (acc_w) begin
      sb.push_back(eject);
      mrx++;
    end
    if (!rst && push && mcnt == DEPTH) begin
      movf = 1'b1;
      if (mdrop < 16'hFFFF) mdrop++;
    end
    mcnt = mcnt + int'(acc_w) - int'(acc_r);
    if (rst) begin
      mcnt = 0;
      movf = 1'b0;
      sb.delete();
      mrx = 0;
      mdrop = 0;
    end
    @(posedge clk);
    #1;
    chk("level", W'(level), W'(mcnt));
    chk("bfull", W'(bfull), W'(mcnt == DEPTH));
    chk("overflow", W'(overflow), W'(movf));
`ifdef EJECT_RX_STATS_EN
    chk("rx_count", W'(rx_count), W'(mrx));
    chk("drop_count", W'(drop_count), W'(mdrop));
`endif
  endtask

  typedef struct {
    logic         push;
    logic [W-1:0] data;
    logic         ready;
    int           lvl;
    logic         full;
    logic         ovf;
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{1'b1, 144'hA0, 1'b0, 1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 144'hA1, 1'b0, 2, 1'b0, 1'b0};
    vt[2] = '{1'b1, 144'hA2, 1'b0, 3, 1'b0, 1'b0};
    vt[3] = '{1'b1, 144'hA3, 1'b0, 4, 1'b1, 1'b0};
    vt[4] = '{1'b1, 144'hA4, 1'b0, 4, 1'b1, 1'b1};
    vt[5] = '{1'b0, 144'h0,  1'b1, 3, 1'b0, 1'b1};
    vt[6] = '{1'b0, 144'h0,  1'b1, 2, 1'b0, 1'b1};
    vt[7] = '{1'b0, 144'h0,  1'b1, 1, 1'b0, 1'b1};
    vt[8] = '{1'b0, 144'h0,  1'b1, 0, 1'b0, 1'b1};

    rst = 1'b1;
    push = 1'b1;
    eject = T0;
    dout_ready = 1'b0;
    #1;
    step();
    step();
    rst = 1'b0;
    push = 1'b0;
    chk("rst_dout", dout, '0);
    chk("rst_valid", W'(dout_valid), W'(0));

    // single flit in, then out
    push = 1'b1;
    eject = T0;
    step();
    push = 1'b0;
    eject = {W{1'b1}};
    chk("single_dout", dout, T0);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    chk("single_empty", W'(dout_valid), W'(0));

    // fill, overflow, drain
    for (int i = 0; i < 9; i++) begin
      push = vt[i].push;
      eject = vt[i].data;
      dout_ready = vt[i].ready;
      step();
      chk($sformatf("vec%0d_level", i), W'(level), W'(vt[i].lvl));
      chk($sformatf("vec%0d_bfull", i), W'(bfull), W'(vt[i].full));
      chk($sformatf("vec%0d_ovf", i), W'(overflow), W'(vt[i].ovf));
    end
    push = 1'b0;
    dout_ready = 1'b0;

    // full with simultaneous pop and push
    for (int i = 0; i < DEPTH; i++) begin
      push = 1'b1;
      eject = W'(144'hC0 + i);
      step();
    end
    eject = 144'hB0;
    dout_ready = 1'b1;
    step();
    chk("fullpop_level", W'(level), W'(3));
    chk("fullpop_ovf", W'(overflow), W'(1));
    eject = 144'hB1;
    dout_ready = 1'b0;
    step();
    chk("b1_level", W'(level), W'(4));
    push = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    chk("drain_level", W'(level), W'(0));

    // streaming across pointer wrap
    for (int i = 0; i < 10; i++) begin
      push = 1'b1;
      eject = W'(144'h100 + i);
      step();
      chk("stream_level_le1", W'(level <= 1), W'(1));
      chk("stream_bfull", W'(bfull), W'(0));
      chk("stream_head", dout, W'(144'h100 + i));
    end
    push = 1'b0;
    step();

    // reset mid-stream
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1;
      eject = W'(144'h200 + i);
      step();
    end
    chk("pre_rst_level", W'(level), W'(3));
    rst = 1'b1;
    dout_ready = 1'b1;
    step();
    rst = 1'b0;
    push = 1'b0;
    dout_ready = 1'b0;
    chk("mid_rst_level", W'(level), W'(0));
    chk("mid_rst_valid", W'(dout_valid), W'(0));
    chk("mid_rst_dout", dout, '0);
`ifdef EJECT_RX_STATS_EN
    chk("mid_rst_rx", W'(rx_count), W'(0));
    chk("mid_rst_drop", W'(drop_count), W'(0));
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
